// File: rtl/avalon_multi_timer.sv
// NUM_CH independent Avalon-MM down-counter timers with snapshot, one-shot/continuous mode and maskable irq.
// Optional per-channel 8-bit tick prescaler is compiled in with AVALON_MULTI_TIMER_PRESCALER_EN.
module avalon_multi_timer #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 99,
  parameter int AW           = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_ch,
  output logic              irq
);

  localparam logic [1:0]       REG_STATUS  = 2'd0;
  localparam logic [1:0]       REG_CONTROL = 2'd1;
  localparam logic [1:0]       REG_PERIOD  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_RST     = CNT_W'(RESET_PERIOD);

  logic          wr;
  logic [AW-1:0] ch_sel;
  logic [1:0]    reg_sel;
  logic          unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign ch_sel       = address >> 2;
  assign reg_sel      = address[1:0];
  assign unused_wdata = ^writedata;

  logic [NUM_CH-1:0] to_q, to_d;
  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] ito_q, ito_d;
  logic [NUM_CH-1:0] cont_q, cont_d;
  logic [NUM_CH-1:0] force_reload_q, force_reload_d;
  logic [NUM_CH-1:0] irq_ch_q, irq_ch_d;
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  snap_q   [NUM_CH];
  logic [CNT_W-1:0]  snap_d   [NUM_CH];
  logic [31:0]       readdata_q, readdata_d;
`ifdef AVALON_MULTI_TIMER_PRESCALER_EN
  logic [7:0]        prescale_q [NUM_CH];
  logic [7:0]        prescale_d [NUM_CH];
  logic [7:0]        pcnt_q     [NUM_CH];
  logic [7:0]        pcnt_d     [NUM_CH];
`endif

  logic [NUM_CH-1:0] wr_status, wr_ctrl, wr_period, wr_snap;
  logic [NUM_CH-1:0] tick, cnt_zero, timeout;

  // Out-of-range channel indices never match any n, so they fall through silently.
  always_comb begin
    wr_status = '0;
    wr_ctrl   = '0;
    wr_period = '0;
    wr_snap   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (wr && (ch_sel == AW'(n))) begin
        wr_status[n] = (reg_sel == REG_STATUS);
        wr_ctrl[n]   = (reg_sel == REG_CONTROL);
        wr_period[n] = (reg_sel == REG_PERIOD);
        wr_snap[n]   = (reg_sel == 2'd3);
      end
    end
  end

  always_comb begin
    tick     = '0;
    cnt_zero = '0;
    for (int n = 0; n < NUM_CH; n++) begin
`ifdef AVALON_MULTI_TIMER_PRESCALER_EN
      tick[n] = (pcnt_q[n] == prescale_q[n]);
`else
      tick[n] = 1'b1;
`endif
      cnt_zero[n] = (cnt_q[n] == '0);
    end
  end

  // A pending force_reload swallows the terminal count, so no timeout is reported.
  assign timeout = run_q & tick & cnt_zero & ~force_reload_q;

  always_comb begin
    to_d           = to_q;
    run_d          = run_q;
    ito_d          = ito_q;
    cont_d         = cont_q;
    period_d       = period_q;
    cnt_d          = cnt_q;
    snap_d         = snap_q;
    force_reload_d = wr_period;
    irq_ch_d       = to_q & ito_q;
`ifdef AVALON_MULTI_TIMER_PRESCALER_EN
    prescale_d     = prescale_q;
    pcnt_d         = pcnt_q;
`endif
    for (int n = 0; n < NUM_CH; n++) begin
      if (wr_ctrl[n]) begin
        ito_d[n]  = writedata[0];
        cont_d[n] = writedata[1];
`ifdef AVALON_MULTI_TIMER_PRESCALER_EN
        prescale_d[n] = writedata[15:8];
`endif
      end
      if (wr_period[n]) begin
        period_d[n] = writedata[CNT_W-1:0];
      end
      if (wr_snap[n]) begin
        snap_d[n] = cnt_q[n];
      end

      if (force_reload_q[n]) begin
        cnt_d[n] = period_q[n];
      end else if (run_q[n] && tick[n]) begin
        cnt_d[n] = cnt_zero[n] ? period_q[n] : cnt_q[n] - CNT_W'(1);
      end

      // START outranks STOP, a pending reload and a one-shot expiry.
      if (wr_ctrl[n] && writedata[2]) begin
        run_d[n] = 1'b1;
      end else if (wr_ctrl[n] && writedata[3]) begin
        run_d[n] = 1'b0;
      end else if (force_reload_q[n]) begin
        run_d[n] = 1'b0;
      end else if (timeout[n] && !cont_q[n]) begin
        run_d[n] = 1'b0;
      end

      if (wr_status[n]) begin
        to_d[n] = 1'b0;
      end else if (timeout[n]) begin
        to_d[n] = 1'b1;
      end

`ifdef AVALON_MULTI_TIMER_PRESCALER_EN
      if (wr_ctrl[n] || force_reload_q[n] || tick[n]) begin
        pcnt_d[n] = 8'd0;
      end else begin
        pcnt_d[n] = pcnt_q[n] + 8'd1;
      end
`endif
    end
  end

  always_comb begin
    readdata_d = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_sel == AW'(n)) begin
        case (reg_sel)
          REG_STATUS:  readdata_d = {30'd0, run_q[n], to_q[n]};
`ifdef AVALON_MULTI_TIMER_PRESCALER_EN
          REG_CONTROL: readdata_d = {16'd0, prescale_q[n], 6'd0, cont_q[n], ito_q[n]};
`else
          REG_CONTROL: readdata_d = {30'd0, cont_q[n], ito_q[n]};
`endif
          REG_PERIOD:  readdata_d = 32'(period_q[n]);
          default:     readdata_d = 32'(snap_q[n]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q           <= '0;
      run_q          <= '0;
      ito_q          <= '0;
      cont_q         <= '0;
      force_reload_q <= '0;
      irq_ch_q       <= '0;
      readdata_q     <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        period_q[n] <= CNT_RST;
        cnt_q[n]    <= CNT_RST;
        snap_q[n]   <= '0;
`ifdef AVALON_MULTI_TIMER_PRESCALER_EN
        prescale_q[n] <= '0;
        pcnt_q[n]     <= '0;
`endif
      end
    end else begin
      to_q           <= to_d;
      run_q          <= run_d;
      ito_q          <= ito_d;
      cont_q         <= cont_d;
      force_reload_q <= force_reload_d;
      irq_ch_q       <= irq_ch_d;
      readdata_q     <= readdata_d;
      period_q       <= period_d;
      cnt_q          <= cnt_d;
      snap_q         <= snap_d;
`ifdef AVALON_MULTI_TIMER_PRESCALER_EN
      prescale_q     <= prescale_d;
      pcnt_q         <= pcnt_d;
`endif
    end
  end

  assign readdata = readdata_q;
  assign irq_ch   = irq_ch_q;
  assign irq      = |irq_ch_q;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Directed/randomised bench for avalon_multi_timer (3 channels so an out-of-range channel is addressable).
// Expected values come from arithmetic timing rules; AVALON_MULTI_TIMER_PRESCALER_EN selects the tick rule.
module tb_avalon_multi_timer;

  localparam int NUM_CH       = 3;
  localparam int CNT_W        = 32;
  localparam int RESET_PERIOD = 99;
  localparam int AW           = $clog2(NUM_CH) + 2;
`ifdef AVALON_MULTI_TIMER_PRESCALER_EN
  localparam bit PRESC_EN = 1'b1;
`else
  localparam bit PRESC_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [AW-1:0]     address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] irq_ch;
  logic              irq;

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;

  avalon_multi_timer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_PERIOD(RESET_PERIOD), .AW(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_ch(irq_ch), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick1();
  endtask

  // The write lands on the edge that ends this task; cyc then names that edge.
  task automatic bus_write(input int ch, input int rg, input logic [31:0] d);
    address    = AW'(ch * 4 + rg);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick1();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input int ch, input int rg, output logic [31:0] d);
    address = AW'(ch * 4 + rg);
    tick1();
    d = readdata;
  endtask

  // Continuous counter started at edge k with value p: value held after edge e.
  function automatic int cnt_after(int p, int k, int e);
    return p - ((e - k) % (p + 1));
  endfunction

  function automatic bit is_to(int p, int k, int e);
    return (e > k) && (((e - k) % (p + 1)) == 0);
  endfunction

  function automatic bit to_since(int p, int k, int c, int x);
    for (int t = c + 1; t <= x; t++) begin
      if (is_to(p, k, t)) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    logic [31:0] rd;
    int p, p0, p1, pb, pc, k, k0, k1, w, d, c, t, ps, lat, ch;
    bit e1;

    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_irq_ch", 32'(irq_ch), 32'd0);
    reset_n = 1'b1;
    tick1();
    bus_read(0, 0, rd); check("rst_status", rd, 32'h0);
    bus_read(0, 2, rd); check("rst_period", rd, 32'(RESET_PERIOD));
    bus_read(0, 1, rd); check("rst_control", rd, 32'h0);
    bus_read(0, 3, rd); check("rst_snap", rd, 32'h0);

    // One-shot on ch1; START lands on the force_reload edge and must win.
    p = $urandom_range(2, 20);
    bus_write(1, 2, 32'(p));
    bus_write(1, 1, 32'h5);
    k = cyc;
    for (int i = 0; i < p + 3; i++) begin
      tick1();
      check("oneshot_irq", 32'(irq_ch), {29'd0, 1'b0, (cyc >= k + p + 2), 1'b0});
    end
    bus_read(1, 0, rd); check("oneshot_status", rd, 32'h1);
    repeat (p + 2) tick1();
    bus_read(1, 0, rd); check("oneshot_stays_stopped", rd, 32'h1);
    bus_write(1, 3, 32'h0);
    bus_read(1, 3, rd); check("oneshot_reloaded", rd, 32'(p));
    bus_write(1, 0, 32'h0);
    check("clr_irq_same_edge", 32'(irq), 32'd1);
    tick1();
    check("clr_irq_next_edge", 32'(irq), 32'd0);

    // Two continuous channels.
    p0 = $urandom_range(5, 12);
    p1 = $urandom_range(1, 4);
    bus_write(0, 2, 32'(p0));
    bus_write(1, 2, 32'(p1));
    bus_write(0, 1, 32'h7);
    k0 = cyc;
    bus_write(1, 1, 32'h7);
    k1 = cyc;
    for (int i = 0; i < p0 + 4; i++) begin
      tick1();
      check("cont_irq", 32'(irq_ch), {29'd0, 1'b0, (cyc >= k1 + p1 + 2), (cyc >= k0 + p0 + 2)});
    end
    for (int i = 0; i < 6; i++) begin
      ch = $urandom_range(0, 1);
      repeat ($urandom_range(0, 7)) tick1();
      bus_write(ch, 3, 32'h0);
      w = cyc;
      bus_read(ch, 3, rd);
      check("cont_snap", rd, 32'(ch == 1 ? cnt_after(p1, k1, w - 1) : cnt_after(p0, k0, w - 1)));
    end

    // Clear ch1 TO on the very edge it sets, then watch it come back; ch0 untouched.
    t = cyc + 1;
    while (!is_to(p1, k1, t)) t++;
    wait_until(t - 1);
    bus_write(1, 0, 32'h0);
    c = cyc;
    address = AW'(4);
    for (int i = 0; i < 2 * (p1 + 1) + 2; i++) begin
      tick1();
      e1 = to_since(p1, k1, c, cyc - 1);
      check("clr_status", readdata, {30'd0, 1'b1, e1});
      check("clr_irq_ch", 32'(irq_ch), {29'd0, 1'b0, e1, 1'b1});
    end

    // Snapshot during a one-shot run, then a mid-count PERIOD write.
    pb = $urandom_range(500, 1000);
    bus_write(0, 2, 32'(pb));
    tick1();
    bus_read(0, 0, rd); check("reload_stops", rd, 32'h1);
    bus_write(0, 1, 32'h5);
    k = cyc;
    d = $urandom_range(3, 30);
    wait_until(k + d - 1);
    bus_write(0, 3, 32'h0);
    bus_read(0, 3, rd); check("snap_running", rd, 32'(pb - (d - 1)));
    pc = $urandom_range(20, 99);
    bus_write(0, 2, 32'(pc));
    tick1();
    bus_read(0, 0, rd); check("midcount_status", rd, 32'h1);
    bus_write(0, 3, 32'h0);
    bus_read(0, 3, rd); check("midcount_counter", rd, 32'(pc));
    bus_read(0, 2, rd); check("midcount_period", rd, 32'(pc));

    // START+STOP together, STOP alone, and an unimplemented channel.
    bus_write(2, 1, 32'hC);
    bus_read(2, 0, rd); check("start_stop_run", rd, 32'h2);
    bus_read(2, 1, rd); check("strobes_read0", rd, 32'h0);
    bus_write(2, 1, 32'h8);
    bus_read(2, 0, rd); check("stop_run", rd, 32'h0);
    bus_write(3, 2, $urandom);
    bus_write(3, 1, 32'h7);
    bus_write(3, 3, 32'h0);
    bus_write(3, 0, 32'h0);
    for (int rg = 0; rg < 4; rg++) begin
      bus_read(3, rg, rd); check("oor_read", rd, 32'h0);
    end
    bus_read(2, 2, rd); check("oor_ch2_period", rd, 32'(RESET_PERIOD));
    bus_read(0, 2, rd); check("oor_ch0_period", rd, 32'(pc));
    check("oor_irq_ch", 32'(irq_ch), 32'h3);

    // Prescaled one-shot on ch2 (first pass is the PRESCALE=3, PERIOD=2 case).
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        ps = 3;
        p  = 2;
      end else begin
        ps = $urandom_range(0, 5);
        p  = $urandom_range(1, 4);
      end
      bus_write(2, 0, 32'h0);
      bus_write(2, 2, 32'(p));
      tick1();
      bus_write(2, 1, 32'((ps << 8) | 5));
      k   = cyc;
      lat = PRESC_EN ? (ps + 1) * (p + 1) : (p + 1);
      while (cyc < k + lat + 2) begin
        tick1();
        check("presc_irq", 32'(irq_ch[2]), 32'(cyc >= k + lat + 1));
      end
      bus_read(2, 1, rd); check("presc_control", rd, 32'((PRESC_EN ? (ps << 8) : 0) | 1));
      bus_read(2, 0, rd); check("presc_status", rd, 32'h1);
    end

    // Asynchronous reset in the middle of a cycle.
    bus_write(1, 1, 32'h7);
    repeat (3) tick1();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_irq_ch", 32'(irq_ch), 32'd0);
    check("arst_readdata", readdata, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick1();
    bus_read(1, 0, rd); check("arst_status", rd, 32'h0);
    bus_read(0, 2, rd); check("arst_period", rd, 32'(RESET_PERIOD));
    bus_read(1, 1, rd); check("arst_control", rd, 32'h0);
    bus_read(2, 3, rd); check("arst_snap", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
